// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment bit order is a..g in bits 0..6 with the decimal point in bit 7.
package seg_pkg;

  localparam int         SEG_DP_BIT = 7;
  localparam logic [7:0] SEG_OFF    = 8'h00;

  // Index is the nibble value; bit 7 is left clear so dp can be OR'ed in.
  localparam logic [7:0] SEG_HEX [16] = '{
    8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07,
    8'h7f, 8'h6f, 8'h77, 8'h7c, 8'h39, 8'h5e, 8'h79, 8'h71
  };

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-segment decoder with decimal point insertion.
// One instance per digit group.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg             = SEG_HEX[nibble];
    seg[SEG_DP_BIT] = dp;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a two-group seven-segment display with
// frame-aligned double buffering and a dark guard interval per digit slot.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    clk_pin,
  input  logic                    rst_pin,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load_in,
  output logic                    frame_done,
  output logic [7:0]              seg_data_0_pin,
  output logic [7:0]              seg_data_1_pin,
  output logic [NUM_DIGITS-1:0]   seg_cs_pin
);

  localparam int HALF = NUM_DIGITS / 2;
  localparam int TW   = $clog2(TICK_DIV);
  localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [TW-1:0]         TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(HALF - 1);
  localparam logic [TW-1:0]         GUARD_LAST = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [NUM_DIGITS-1:0] CS_ONE     = NUM_DIGITS'(1);
  localparam slot_state_e           STATE_INIT = (BLANK_CYCLES > 0) ? GUARD : SHOW;

  logic [TW-1:0]           tick_cnt;
  logic [IW-1:0]           idx;
  slot_state_e             state;

  logic [4*NUM_DIGITS-1:0] stg_value, disp_value;
  logic [NUM_DIGITS-1:0]   stg_dp, disp_dp;
  logic [NUM_DIGITS-1:0]   stg_blank, disp_blank;
  logic                    pending;

  logic                    tick_last, slot_last, boundary;
  logic [3:0]              nib_0, nib_1;
  logic                    dp_0, dp_1, blank_0, blank_1;
  logic [7:0]              hex_0, hex_1;
  logic [7:0]              seg_0_next, seg_1_next;
  logic [NUM_DIGITS-1:0]   cs_next;

  assign tick_last = (tick_cnt == TICK_LAST);
  assign slot_last = (idx == IDX_LAST);
  assign boundary  = tick_last && slot_last;

  // Group 0 scans digit idx, group 1 scans digit HALF+idx in the same slot.
  assign nib_0   = 4'(disp_value >> (4 * idx));
  assign nib_1   = 4'(disp_value >> (4 * (HALF + idx)));
  assign dp_0    = 1'(disp_dp >> idx);
  assign dp_1    = 1'(disp_dp >> (HALF + idx));
  assign blank_0 = 1'(disp_blank >> idx);
  assign blank_1 = 1'(disp_blank >> (HALF + idx));

  seg_hex_decode u_dec_0 (.nibble(nib_0), .dp(dp_0), .seg(hex_0));
  seg_hex_decode u_dec_1 (.nibble(nib_1), .dp(dp_1), .seg(hex_1));

  always_comb begin
    seg_0_next = SEG_OFF;
    seg_1_next = SEG_OFF;
    cs_next    = '0;
    if (state == SHOW) begin
      if (!blank_0) begin
        seg_0_next = hex_0;
        cs_next    = cs_next | (CS_ONE << idx);
      end
      if (!blank_1) begin
        seg_1_next = hex_1;
        cs_next    = cs_next | (CS_ONE << (HALF + idx));
      end
    end
  end

  // Slot counters and the per-slot phase FSM; state stays aligned with tick_cnt.
  always_ff @(posedge clk_pin) begin
    if (rst_pin) begin
      tick_cnt <= '0;
      idx      <= '0;
      state    <= STATE_INIT;
    end else begin
      tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;
      if (tick_last) idx <= slot_last ? '0 : idx + 1'b1;
      case (state)
        GUARD:   if (tick_cnt == GUARD_LAST) state <= SHOW;
        SHOW:    if (tick_last && (BLANK_CYCLES > 0)) state <= GUARD;
        default: state <= STATE_INIT;
      endcase
    end
  end

  // load_in has no back-pressure: every strobe is taken, the last one in a
  // frame wins, and a strobe on the boundary cycle goes straight to display.
  always_ff @(posedge clk_pin) begin
    if (rst_pin) begin
      stg_value  <= '0;
      stg_dp     <= '0;
      stg_blank  <= '1;
      disp_value <= '0;
      disp_dp    <= '0;
      disp_blank <= '1;
      pending    <= 1'b0;
    end else begin
      if (load_in) begin
        stg_value <= value_in;
        stg_dp    <= dp_in;
        stg_blank <= blank_in;
        pending   <= 1'b1;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (load_in) begin
          disp_value <= value_in;
          disp_dp    <= dp_in;
          disp_blank <= blank_in;
        end else if (pending) begin
          disp_value <= stg_value;
          disp_dp    <= stg_dp;
          disp_blank <= stg_blank;
        end
      end
    end
  end

  always_ff @(posedge clk_pin) begin
    if (rst_pin) begin
      frame_done     <= 1'b0;
      seg_data_0_pin <= SEG_OFF;
      seg_data_1_pin <= SEG_OFF;
      seg_cs_pin     <= '0;
    end else begin
      frame_done     <= boundary;
      seg_data_0_pin <= seg_0_next;
      seg_data_1_pin <= seg_1_next;
      seg_cs_pin     <= cs_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized and directed bench for seg_scan_driver against a per-digit
// reference model driven by an absolute cycle position within the frame.
module tb_seg_scan_driver;

  localparam int ND    = 8;
  localparam int TD    = 8;
  localparam int BC    = 2;
  localparam int HALF  = ND / 2;
  localparam int FRAME = TD * HALF;

  // clock/reset and stimulus
  logic            clk_pin  = 1'b0;
  logic            rst_pin  = 1'b1;
  logic [4*ND-1:0] value_in = '0;
  logic [ND-1:0]   dp_in    = '0;
  logic [ND-1:0]   blank_in = '0;
  logic            load_in  = 1'b0;
  logic            frame_done;
  logic [7:0]      seg_data_0_pin, seg_data_1_pin;
  logic [ND-1:0]   seg_cs_pin;

  always #5 clk_pin = ~clk_pin;

  seg_scan_driver #(
    .NUM_DIGITS  (ND),
    .TICK_DIV    (TD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk_pin       (clk_pin),
    .rst_pin       (rst_pin),
    .value_in      (value_in),
    .dp_in         (dp_in),
    .blank_in      (blank_in),
    .load_in       (load_in),
    .frame_done    (frame_done),
    .seg_data_0_pin(seg_data_0_pin),
    .seg_data_1_pin(seg_data_1_pin),
    .seg_cs_pin    (seg_cs_pin)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // reference model
  logic [7:0] hex_ref [16] = '{
    8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07,
    8'h7f, 8'h6f, 8'h77, 8'h7c, 8'h39, 8'h5e, 8'h79, 8'h71
  };

  int         m_t;
  logic [3:0] d_val [ND];
  logic       d_dp [ND];
  logic       d_blank [ND];
  logic [3:0] s_val [ND];
  logic       s_dp [ND];
  logic       s_blank [ND];
  logic       m_pending;
  logic [24:0] exp_q[$];

  task automatic model_reset();
    m_t       = 0;
    m_pending = 1'b0;
    for (int d = 0; d < ND; d++) begin
      d_val[d] = '0; d_dp[d] = 1'b0; d_blank[d] = 1'b1;
      s_val[d] = '0; s_dp[d] = 1'b0; s_blank[d] = 1'b1;
    end
  endtask

  // Expected {frame_done, cs, seg1, seg0} after the coming edge.
  function automatic logic [24:0] model_outputs();
    logic [7:0]    s0, s1, seg;
    logic [ND-1:0] cs;
    logic          fd;
    int            tick, slot, d;
    s0 = 8'h00; s1 = 8'h00; cs = '0; fd = 1'b0;
    if (!rst_pin) begin
      tick = m_t % TD;
      slot = (m_t / TD) % HALF;
      fd   = ((m_t % FRAME) == FRAME - 1);
      if (tick >= BC) begin
        for (int g = 0; g < 2; g++) begin
          d = g * HALF + slot;
          if (!d_blank[d]) begin
            seg   = hex_ref[d_val[d]] | (d_dp[d] ? 8'h80 : 8'h00);
            cs[d] = 1'b1;
            if (g == 0) s0 = seg; else s1 = seg;
          end
        end
      end
    end
    return {fd, cs, s1, s0};
  endfunction

  task automatic model_step();
    if (rst_pin) begin
      model_reset();
    end else begin
      if ((m_t % FRAME) == FRAME - 1) begin
        for (int d = 0; d < ND; d++) begin
          if (load_in) begin
            d_val[d] = value_in[4*d +: 4]; d_dp[d] = dp_in[d]; d_blank[d] = blank_in[d];
          end else if (m_pending) begin
            d_val[d] = s_val[d]; d_dp[d] = s_dp[d]; d_blank[d] = s_blank[d];
          end
        end
        m_pending = 1'b0;
      end else if (load_in) begin
        for (int d = 0; d < ND; d++) begin
          s_val[d] = value_in[4*d +: 4]; s_dp[d] = dp_in[d]; s_blank[d] = blank_in[d];
        end
        m_pending = 1'b1;
      end
      m_t = (m_t + 1) % FRAME;
    end
  endtask

  // driver tasks
  task automatic run_cycle();
    logic [24:0] e;
    exp_q.push_back(model_outputs());
    model_step();
    @(posedge clk_pin);
    #1;
    e = exp_q.pop_front();
    check_val("seg0", 32'(seg_data_0_pin), 32'(e[7:0]));
    check_val("seg1", 32'(seg_data_1_pin), 32'(e[15:8]));
    check_val("cs", 32'(seg_cs_pin), 32'(e[23:16]));
    check_val("frame_done", 32'(frame_done), 32'(e[24]));
  endtask

  // Run until the model's frame position equals p (bounded).
  task automatic run_to(input int p);
    int n;
    n = 0;
    while (m_t != p && n < 4 * FRAME) begin
      run_cycle();
      n++;
    end
    check_val("run_to_pos", 32'(m_t), 32'(p));
  endtask

  task automatic pulse_load(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] bl);
    value_in = v; dp_in = dp; blank_in = bl; load_in = 1'b1;
    run_cycle();
    load_in = 1'b0;
  endtask

  initial begin
    int fd_cycle;
    int fd_count;
    model_reset();

    // reset held 3 cycles, then one dark frame
    rst_pin = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle();
    rst_pin  = 1'b0;
    fd_cycle = -1;
    for (int i = 1; i <= FRAME; i++) begin
      run_cycle();
      if (frame_done && fd_cycle < 0) fd_cycle = i;
    end
    check_val("first_fd_cycle", 32'(fd_cycle), 32'd32);

    // basic load, shown from the next frame
    pulse_load(32'h7654_3210, 8'h00, 8'h00);
    run_to(0);
    run_to(3);
    check_val("slot0_seg0", 32'(seg_data_0_pin), 32'h3f);
    check_val("slot0_seg1", 32'(seg_data_1_pin), 32'h66);
    check_val("slot0_cs", 32'(seg_cs_pin), 32'h11);
    run_to(27);
    check_val("slot3_seg0", 32'(seg_data_0_pin), 32'h4f);
    check_val("slot3_seg1", 32'(seg_data_1_pin), 32'h07);
    check_val("slot3_cs", 32'(seg_cs_pin), 32'h88);

    // two loads in one frame, last wins, nothing changes mid-frame
    run_to(10);
    pulse_load(32'h0000_0001, 8'h00, 8'h00);
    run_to(14);
    pulse_load(32'h0000_000F, 8'h00, 8'h00);
    run_to(27);
    check_val("held_seg0", 32'(seg_data_0_pin), 32'h4f);
    run_to(0);
    run_to(3);
    check_val("last_load_seg0", 32'(seg_data_0_pin), 32'h71);
    check_val("last_load_seg1", 32'(seg_data_1_pin), 32'h3f);

    // load on the boundary cycle bypasses staging
    run_to(FRAME - 1);
    pulse_load(32'h0000_0080, 8'h02, 8'hFC);
    run_to(3);
    check_val("bypass_d0_seg0", 32'(seg_data_0_pin), 32'h3f);
    check_val("bypass_d0_cs", 32'(seg_cs_pin), 32'h01);
    run_to(11);
    check_val("bypass_d1_seg0", 32'(seg_data_0_pin), 32'hff);
    check_val("bypass_d1_seg1", 32'(seg_data_1_pin), 32'h00);
    check_val("bypass_d1_cs", 32'(seg_cs_pin), 32'h02);

    // random loads over several frames
    for (int i = 0; i < 6 * FRAME; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        pulse_load($urandom, 8'($urandom_range(0, 255)),
                   8'($urandom_range(0, 255) & $urandom_range(0, 255)));
      end else begin
        run_cycle();
      end
    end

    // reset mid slot 2
    run_to(20);
    rst_pin = 1'b1;
    run_cycle();
    rst_pin = 1'b0;
    check_val("rst_cs", 32'(seg_cs_pin), 32'h0);
    check_val("rst_seg0", 32'(seg_data_0_pin), 32'h0);
    fd_count = 0;
    for (int i = 0; i < FRAME - 1; i++) begin
      run_cycle();
      if (frame_done) fd_count++;
    end
    check_val("no_fd_after_rst", 32'(fd_count), 32'd0);
    run_cycle();
    check_val("fd_after_rst_frame", 32'(frame_done), 32'd1);
    for (int i = 0; i < FRAME; i++) run_cycle();

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
